// File: rtl/hid_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hid_pkg;

    // Device-to-host frame deframer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Scan-code prefixes absorbed by the receiver
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic ps2_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Scan-code write bundle from the PS/2 receiver into the HID scan FIFO.
// Latency: n/a (wires only).
// Backpressure: none; scan_valid_o is a write strobe the FIFO must accept.
interface ps2_kbd_rx_if;
    logic       scan_valid_o;
    logic [7:0] scan_code_o;
    logic       scan_released_o;
    logic       scan_extended_o;
    logic       parity_err_o;
    logic       frame_err_o;

    // Receiver drives the bundle
    modport master (
        output scan_valid_o, scan_code_o, scan_released_o, scan_extended_o,
               parity_err_o, frame_err_o
    );

    // FIFO / status logic consumes it
    modport slave (
        input  scan_valid_o, scan_code_o, scan_released_o, scan_extended_o,
               parity_err_o, frame_err_o
    );
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus stability filter for one PS/2 line.
// Latency: 2 sync cycles + FILTER_LEN stable cycles before filt_o follows.
// Backpressure: none; free-running.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic filt_o
);

    localparam int              CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Synchronise the raw pin; idle PS/2 lines are high so reset to 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that differ from the filtered value; any
    // return to the filtered value restarts the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync2_q == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            filt_q <= sync2_q;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks parity, strips E0/F0 prefixes.
// Latency: valid/error pulse 1 cycle after the filtered stop-bit sample event.
// Backpressure: none; one scan_valid_o write per key event, FIFO must accept it.
module ps2_kbd_rx
    import hid_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ps2_clk_i,
    input  logic            ps2_data_i,
    ps2_kbd_rx_if.master    kbd
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ps2_clk_filt;
    logic ps2_dat_filt;
    logic ps2_clk_prev_q;
    logic sample;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (ps2_clk_i),
        .filt_o (ps2_clk_filt)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (ps2_data_i),
        .filt_o (ps2_dat_filt)
    );

    // Remember the previous filtered clock to find falling edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ps2_clk_prev_q <= 1'b1;
        else         ps2_clk_prev_q <= ps2_clk_filt;
    end

    assign sample = ps2_clk_prev_q & ~ps2_clk_filt;

    ps2_state_e    state_q,   state_d;
    logic [7:0]    shift_q,   shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q,     par_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          ext_q,     ext_d;
    logic          rel_q,     rel_d;
    logic          vld_q,     vld_d;
    logic [7:0]    code_q,    code_d;
    logic          code_rel_q, code_rel_d;
    logic          code_ext_q, code_ext_d;
    logic          perr_q,    perr_d;
    logic          ferr_q,    ferr_d;

    // State and output registers; everything clears on reset so a partial
    // frame is silently discarded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            vld_q      <= 1'b0;
            code_q     <= '0;
            code_rel_q <= 1'b0;
            code_ext_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            vld_q      <= vld_d;
            code_q     <= code_d;
            code_rel_q <= code_rel_d;
            code_ext_q <= code_ext_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Frame deframer, timeout supervision and prefix absorption
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        tmo_d      = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
        ext_d      = ext_q;
        rel_d      = rel_q;
        vld_d      = 1'b0;
        code_d     = code_q;
        code_rel_d = code_rel_q;
        code_ext_d = code_ext_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        // Timeout wins over a coincident sample event
        if (state_q != IDLE && tmo_q == TMO_LAST) begin
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            tmo_d   = '0;
            state_d = IDLE;
        end else if (sample) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    // High data on a falling edge is noise, not a start bit
                    if (!ps2_dat_filt) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {ps2_dat_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = ps2_dat_filt;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!ps2_dat_filt) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end else if (!ps2_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end else if (shift_q == PS2_PFX_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_PFX_BRK) begin
                        rel_d = 1'b1;
                    end else begin
                        vld_d      = 1'b1;
                        code_d     = shift_q;
                        code_rel_d = rel_q;
                        code_ext_d = ext_q;
                        ext_d      = 1'b0;
                        rel_d      = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign kbd.scan_valid_o    = vld_q;
    assign kbd.scan_code_o     = code_q;
    assign kbd.scan_released_o = code_rel_q;
    assign kbd.scan_extended_o = code_ext_q;
    assign kbd.parity_err_o    = perr_q;
    assign kbd.frame_err_o     = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx with a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_kbd_rx;

    localparam int L = 8;      // FILTER_LEN
    localparam int T = 400;    // TIMEOUT_CYCLES (scaled down to keep runs short)
    localparam int H = 20;     // PS/2 half bit period in clk_i cycles (scaled)

    logic clk_i      = 1'b0;
    logic rst_ni     = 1'b0;
    logic ps2_clk_i  = 1'b1;
    logic ps2_data_i = 1'b1;

    always #5 clk_i = ~clk_i;

    ps2_kbd_rx_if kbd ();

    ps2_kbd_rx #(.FILTER_LEN(L), .TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .kbd        (kbd)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  fall_cyc;
    int  last_valid_cyc;
    int  last_ferr_cyc;
    int  perr_n, ferr_n, exp_perr, exp_ferr;
    bit  glitch_en = 1'b0;
    bit  m_ext, m_rel;
    ev_t obs_q[$];
    ev_t exp_q[$];

    always @(posedge clk_i) cyc++;

    // Collect everything the receiver emits
    always @(negedge clk_i) begin
        if (kbd.scan_valid_o) begin
            ev_t e;
            e.code = kbd.scan_code_o;
            e.rel  = kbd.scan_released_o;
            e.ext  = kbd.scan_extended_o;
            obs_q.push_back(e);
            last_valid_cyc = cyc;
        end
        if (kbd.parity_err_o) perr_n++;
        if (kbd.frame_err_o) begin
            ferr_n++;
            last_ferr_cyc = cyc;
        end
    end

    // Reference model: kind 0 good, 1 bad parity, 2 bad stop, 3 timeout
    task automatic model_frame(input logic [7:0] b, input int kind);
        if (kind != 0) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
            if (kind == 1) exp_perr++;
            else           exp_ferr++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            ev_t e;
            e.code = b;
            e.rel  = m_rel;
            e.ext  = m_ext;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        perr_n   = 0;
        ferr_n   = 0;
        exp_perr = 0;
        exp_ferr = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data_i = b;
        tick(4);
        if (glitch_en) begin
            ps2_clk_i = 1'b0;
            tick(L - 1);
            ps2_clk_i = 1'b1;
            tick(H - 4 - (L - 1));
        end else begin
            tick(H - 4);
        end
        ps2_clk_i = 1'b0;
        fall_cyc  = cyc;
        tick(5);
        if (glitch_en) begin
            ps2_clk_i = 1'b1;
            tick(L - 1);
            ps2_clk_i = 1'b0;
            tick(H - 5 - (L - 1));
        end else begin
            tick(H - 5);
        end
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        logic p;
        p = ~^b;
        if (kind == 1) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(kind == 2 ? 1'b0 : 1'b1);
        ps2_data_i = 1'b1;
        tick(2 * H);
        model_frame(b, kind);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(3);
        n_chk++; if (kbd.scan_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", kbd.scan_valid_o); end
        n_chk++; if (kbd.scan_code_o !== 8'h00) begin n_fail++; $display("FAIL reset_code got %h want 00", kbd.scan_code_o); end
        n_chk++; if ({kbd.scan_released_o, kbd.scan_extended_o} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {kbd.scan_released_o, kbd.scan_extended_o}); end
        n_chk++; if ({kbd.parity_err_o, kbd.frame_err_o} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b want 00", {kbd.parity_err_o, kbd.frame_err_o}); end
        rst_ni = 1'b1;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        tick(5);
        clear_obs();
    endtask

    task automatic test_make();
        clear_obs();
        send_frame(8'h1C, 0);
        n_chk++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL make_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_chk++; if (obs_q[0] !== {8'h1C, 1'b0, 1'b0}) begin n_fail++; $display("FAIL make_event got %h want %h", obs_q[0], {8'h1C, 2'b00}); end
        end
        // Pulse is one cycle after the filtered stop sample: 2 sync + L filter + edge reg
        n_chk++; if (last_valid_cyc - fall_cyc !== L + 3) begin n_fail++; $display("FAIL make_latency got %0d want %0d", last_valid_cyc - fall_cyc, L + 3); end
        n_chk++; if (perr_n + ferr_n !== 0) begin n_fail++; $display("FAIL make_errs got %0d want 0", perr_n + ferr_n); end
    endtask

    task automatic test_prefix();
        clear_obs();
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        n_chk++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL brk_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_chk++; if (obs_q[0] !== {8'h1C, 1'b1, 1'b0}) begin n_fail++; $display("FAIL brk_event got %h want %h", obs_q[0], {8'h1C, 2'b10}); end
        end
        clear_obs();
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h1C, 0);
        n_chk++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL extbrk_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            n_chk++; if (obs_q[0] !== {8'h75, 1'b1, 1'b1}) begin n_fail++; $display("FAIL extbrk_event got %h want %h", obs_q[0], {8'h75, 2'b11}); end
            n_chk++; if (obs_q[1] !== {8'h1C, 1'b0, 1'b0}) begin n_fail++; $display("FAIL flags_cleared got %h want %h", obs_q[1], {8'h1C, 2'b00}); end
        end
        tick(50);
        n_chk++; if (kbd.scan_code_o !== 8'h1C) begin n_fail++; $display("FAIL code_hold got %h want 1c", kbd.scan_code_o); end
    endtask

    task automatic test_parity();
        clear_obs();
        send_frame(8'h1C, 1);
        n_chk++; if (perr_n !== 1 || ferr_n !== 0) begin n_fail++; $display("FAIL parity_pulse got p=%0d f=%0d want p=1 f=0", perr_n, ferr_n); end
        n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL parity_novalid got %0d want 0", obs_q.size()); end
        clear_obs();
        send_frame(8'hF0, 0);
        send_frame(8'h33, 1);
        send_frame(8'h1C, 0);
        n_chk++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== {8'h1C, 2'b00})) begin n_fail++; $display("FAIL parity_clears_flags got n=%0d ev=%h want n=1 ev=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, {8'h1C, 2'b00}); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_frame(8'h1C, 2);
        n_chk++; if (ferr_n !== 1 || perr_n !== 0 || obs_q.size() !== 0) begin n_fail++; $display("FAIL stop_err got f=%0d p=%0d v=%0d want f=1 p=0 v=0", ferr_n, perr_n, obs_q.size()); end
        clear_obs();
        send_frame(8'hF0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data_i = 1'b1;
        tick(L + T + 40);
        model_frame(8'h00, 3);
        n_chk++; if (ferr_n !== 1 || obs_q.size() !== 0) begin n_fail++; $display("FAIL timeout_pulse got f=%0d v=%0d want f=1 v=0", ferr_n, obs_q.size()); end
        n_chk++; if (last_ferr_cyc - fall_cyc !== L + 3 + T) begin n_fail++; $display("FAIL timeout_delay got %0d want %0d", last_ferr_cyc - fall_cyc, L + 3 + T); end
        send_frame(8'h29, 0);
        n_chk++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== {8'h29, 2'b00})) begin n_fail++; $display("FAIL after_timeout got n=%0d ev=%h want n=1 ev=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, {8'h29, 2'b00}); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        clear_obs();
        b = 8'($urandom_range(1, 8'h7F));
        glitch_en = 1'b1;
        send_frame(b, 0);
        glitch_en = 1'b0;
        n_chk++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== {b, 2'b00})) begin n_fail++; $display("FAIL glitch_decode got n=%0d ev=%h want n=1 ev=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, {b, 2'b00}); end
        n_chk++; if (perr_n + ferr_n !== 0) begin n_fail++; $display("FAIL glitch_errs got %0d want 0", perr_n + ferr_n); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_frame(8'hF0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        rst_ni = 1'b0;
        tick(2);
        n_chk++; if ({kbd.scan_valid_o, kbd.scan_code_o, kbd.scan_released_o, kbd.scan_extended_o, kbd.parity_err_o, kbd.frame_err_o} !== 13'h0) begin n_fail++; $display("FAIL midreset_outputs got code=%h want all 0", kbd.scan_code_o); end
        ps2_data_i = 1'b1;
        rst_ni = 1'b1;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        tick(T + 50);
        n_chk++; if (obs_q.size() + perr_n + ferr_n !== 0) begin n_fail++; $display("FAIL midreset_silent got %0d events want 0", obs_q.size() + perr_n + ferr_n); end
        send_frame(8'h5A, 0);
        n_chk++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0] !== {8'h5A, 2'b00})) begin n_fail++; $display("FAIL midreset_next got n=%0d ev=%h want n=1 ev=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, {8'h5A, 2'b00}); end
    endtask

    task automatic test_random();
        int r;
        int n;
        clear_obs();
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    send_frame(8'hE0, 0);
                2, 3:    send_frame(8'hF0, 0);
                4:       send_frame(8'($urandom), 1);
                5:       send_frame(8'($urandom), 2);
                default: send_frame(8'($urandom), 0);
            endcase
        end
        send_frame(8'h12, 0);
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (perr_n !== exp_perr) begin n_fail++; $display("FAIL rand_parity got %0d want %0d", perr_n, exp_perr); end
        n_chk++; if (ferr_n !== exp_ferr) begin n_fail++; $display("FAIL rand_frame got %0d want %0d", ferr_n, exp_ferr); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
